spike_event_scheduler: RTL and testbench
========================================

Name: spike_event_scheduler

Overview:
- Time-multiplexes one output-neuron datapath (weight ROM plus IF accumulator) across N_IN presynaptic spike lines.
- Per timestep it captures the input spike vector and issues one weight-read event per cycle, LSB first.
- It then waits for the registered ROM-to-accumulator pipeline to settle and signals step completion.
- Sits between the hidden-layer spike outputs and the output neuron's spike_in/addr_in ports.

Parameters:
N_IN, 8, number of presynaptic spike lines (ROM depth).
ADDR_W, 3, event address width; must equal clog2(N_IN).
DRAIN_CYC, 2, cycles waited after the last event (ROM output register plus membrane update). Must be >=1.
CNT_W, 8, width of the dropped-step counter (optional feature).

Ports:
clk  in  1  clock, all logic on rising edge
resetn  in  1  synchronous, active-high reset (high = reset, despite the name)
step_start  in  1  one-cycle request to process a timestep
spike_vec  in  N_IN  input spikes, sampled only in the cycle step_start is accepted
busy  out  1  high whenever state != IDLE
evt_valid  out  1  drives neuron spike_in; one weight event this cycle
evt_addr  out  ADDR_W  drives neuron addr_in; index of the issued spike
step_done  out  1  one-cycle pulse: all events of the step are integrated
overrun  out  1  sticky flag for a dropped step_start (optional feature)
drop_cnt  out  CNT_W  saturating count of dropped step_start (optional feature)

Behaviour:
- Reset: state=IDLE, pending=0, busy=0, evt_valid=0, evt_addr=0, step_done=0, overrun=0, drop_cnt=0 from the cycle after resetn is sampled high.
  - Reset mid-step aborts the step: remaining events are discarded and no step_done is produced.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE with step_start=1 (cycle T):
  - pending <= spike_vec.
  - Next state is ISSUE if spike_vec != 0, else DRAIN with drain_cnt <= DRAIN_CYC-1.
- ISSUE:
  - pending is never 0 in this state.
  - evt_valid=1 and evt_addr = index of the lowest set bit of pending. Both are combinational from state/pending, so they are valid in the same cycle.
  - That bit is cleared at the clock edge.
  - If pending has exactly one bit set, next state is DRAIN with drain_cnt <= DRAIN_CYC-1.
- DRAIN: evt_valid=0; decrement drain_cnt; go to DONE when drain_cnt==0.
- DONE: step_done=1 for exactly one cycle, then IDLE.
- Timing for k set bits, step_start accepted at T:
  - Events on cycles T+1 through T+k, ascending address.
  - DRAIN on cycles T+k+1 through T+k+DRAIN_CYC.
  - step_done on cycle T+k+DRAIN_CYC+1.
  - k=0 follows the same formula.
- busy=1 from T+1 through the DONE cycle inclusive. A new step_start is accepted the cycle after DONE.
- step_start while busy (including the DONE cycle) is ignored; spike_vec and the current step are unaffected.
- evt_addr holds 0 whenever evt_valid=0.
- Addressing: evt_addr is ADDR_W bits, so N_IN <= 2**ADDR_W is required. Bits of spike_vec are never reordered or merged.

Optional Feature:
- Macro SPIKE_SCHED_OVERRUN_EN.
- With the macro defined:
  - A step_start ignored while busy sets overrun (sticky; cleared only by reset).
  - The same event increments drop_cnt, saturating at 2**CNT_W-1.
- Without the macro: overrun and drop_cnt remain as ports, tied to 0; no counter logic is synthesised.

Decomposition:
- Package snn_sched_pkg holds:
  - the state encoding (IDLE/ISSUE/DRAIN/DONE);
  - the default DRAIN_CYC value;
  - a helper that computes a one-hot-to-index mask for lowest-set-bit clearing.
- One sub-module, lsb_first_encoder (N_IN -> ADDR_W index plus "exactly one bit set" flag), purely combinational. Used by the ISSUE logic.

Test Plan:
- spike_vec=8'b1010_0100, step_start at T -> evt_addr 2,5,7 on T+1..T+3; evt_valid low on T+4..T+5; step_done on T+6; busy low at T+7.
- spike_vec=0 -> no evt_valid; step_done on T+3.
- spike_vec=8'hFF -> addresses 0..7 on T+1..T+8; step_done on T+11. Check against the neuron model: threshold crossings match a serial-sum reference.
- step_start pulsed on T+2 and on the DONE cycle -> both ignored, event sequence unchanged. With SPIKE_SCHED_OVERRUN_EN: overrun=1, drop_cnt=2. Without: both 0.
- resetn high on T+2 of an 8'b0000_1111 step -> evt_valid=0 from T+3, no step_done. A new step_start afterwards runs cleanly from address 0.
- Back-to-back: step_start on the cycle after DONE is accepted; 255 forced drops hold drop_cnt at 255 (with CNT_W=8).

Source files
------------

// File: rtl/snn_sched_pkg.sv
// Shared types and helpers for the spike event scheduler: FSM encoding,
// default drain length and the lowest-set-bit clearing mask.
package snn_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  localparam int SCHED_DRAIN_CYC = 2;
  localparam int SCHED_MAX_N     = 64;

  // All-ones except the lowest set bit of v; AND with v to retire that bit.
  function automatic logic [SCHED_MAX_N-1:0] lsb_clear_mask(input logic [SCHED_MAX_N-1:0] v);
    return ~(v & (~v + SCHED_MAX_N'(1)));
  endfunction

endpackage

// File: rtl/lsb_first_encoder.sv
// Combinational lowest-set-bit encoder: index of the lowest set bit of vec_i
// plus a flag that exactly one bit is set.
module lsb_first_encoder #(
  parameter int N_IN   = 8,
  parameter int ADDR_W = 3
) (
  input  logic [N_IN-1:0]   vec_i,
  output logic [ADDR_W-1:0] idx_o,
  output logic              single_o
);

  always_comb begin
    idx_o = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = ADDR_W'(i);
    end
  end

  assign single_o = (vec_i != '0) && ((vec_i & (vec_i - N_IN'(1))) == '0);

endmodule

// File: rtl/spike_event_scheduler.sv
// Serialises a captured spike vector into LSB-first weight-read events, drains the
// ROM/membrane pipeline, then pulses step_done. Optional SPIKE_SCHED_OVERRUN_EN adds drop tracking.
module spike_event_scheduler
  import snn_sched_pkg::*;
#(
  parameter int N_IN      = 8,
  parameter int ADDR_W    = 3,
  parameter int DRAIN_CYC = SCHED_DRAIN_CYC,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              step_start,
  input  logic [N_IN-1:0]   spike_vec,
  output logic              busy,
  output logic              evt_valid,
  output logic [ADDR_W-1:0] evt_addr,
  output logic              step_done,
  output logic              overrun,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYC - 1);

  sched_state_e      state_q;
  logic [N_IN-1:0]   pending_q;
  logic [DW-1:0]     drain_q;
  logic [ADDR_W-1:0] lsb_idx;
  logic              lsb_single;
  logic [N_IN-1:0]   pending_clr;

  lsb_first_encoder #(
    .N_IN  (N_IN),
    .ADDR_W(ADDR_W)
  ) u_enc (
    .vec_i   (pending_q),
    .idx_o   (lsb_idx),
    .single_o(lsb_single)
  );

  assign pending_clr = pending_q & N_IN'(lsb_clear_mask(SCHED_MAX_N'(pending_q)));

  // resetn is active-high despite its name.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      drain_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (step_start) begin
            pending_q <= spike_vec;
            drain_q   <= DRAIN_INIT;
            state_q   <= (spike_vec != '0) ? ST_ISSUE : ST_DRAIN;
          end
        end
        ST_ISSUE: begin
          pending_q <= pending_clr;
          if (lsb_single) begin
            drain_q <= DRAIN_INIT;
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_q == '0) state_q <= ST_DONE;
          else               drain_q <= drain_q - DW'(1);
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign evt_valid = (state_q == ST_ISSUE);
  assign evt_addr  = evt_valid ? lsb_idx : '0;
  assign step_done = (state_q == ST_DONE);

`ifdef SPIKE_SCHED_OVERRUN_EN
  logic             overrun_q;
  logic [CNT_W-1:0] drop_q;

  always_ff @(posedge clk) begin
    if (resetn) begin
      overrun_q <= 1'b0;
      drop_q    <= '0;
    end else if (step_start && busy) begin
      overrun_q <= 1'b1;
      if (drop_q != '1) drop_q <= drop_q + CNT_W'(1);
    end
  end

  assign overrun  = overrun_q;
  assign drop_cnt = drop_q;
`else
  assign overrun  = 1'b0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_spike_event_scheduler.sv
// Directed bench for spike_event_scheduler: table of steps run back-to-back plus
// hand-written overrun, abort-by-reset and saturation sequences.
module tb_spike_event_scheduler;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       step_start = 1'b0;
  logic [7:0] spike_vec = '0;
  logic       busy, evt_valid, step_done, overrun;
  logic [2:0] evt_addr;
  logic [7:0] drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spike_event_scheduler dut (
    .clk       (clk),
    .resetn    (resetn),
    .step_start(step_start),
    .spike_vec (spike_vec),
    .busy      (busy),
    .evt_valid (evt_valid),
    .evt_addr  (evt_addr),
    .step_done (step_done),
    .overrun   (overrun),
    .drop_cnt  (drop_cnt)
  );

  // Reference neuron: registered weight ROM (w[i] = i+3), IF membrane, threshold 10, subtractive reset.
  int   mem = 0;
  int   nspk = 0;
  logic rv = 1'b0;
  int   rw = 0;
  always @(posedge clk) begin
    rv <= (evt_valid === 1'b1);
    rw <= (evt_valid === 1'b1) ? int'(evt_addr) + 3 : 0;
    if (rv) begin
      if (mem + rw >= 10) begin
        mem  <= mem + rw - 10;
        nspk <= nspk + 1;
      end else begin
        mem <= mem + rw;
      end
    end
  end

  function automatic int ref_spikes(input int m0, input logic [7:0] v);
    int m = m0;
    int c = 0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        m += i + 3;
        if (m >= 10) begin
          m -= 10;
          c++;
        end
      end
    end
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a step in the current cycle, checks {busy,evt_valid,evt_addr,step_done}
  // for T+1..done_at+1 and returns in the idle cycle after DONE without advancing.
  task automatic run_step(input string tag, input logic [7:0] vec, input int done_at,
                          input int p1, input int p2);
    int         m0, c0, k, cnt;
    logic [2:0] ea;
    logic [5:0] want;
    m0 = mem;
    c0 = nspk;
    k  = $countones(vec);
    spike_vec  = vec;
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    spike_vec  = 8'h5A;
    for (int n = 1; n <= done_at + 1; n++) begin
      ea  = 3'd0;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
        if (vec[i]) begin
          cnt++;
          if (cnt == n) ea = 3'(i);
        end
      end
      want = {(n <= done_at), (n <= k), ea, (n == done_at)};
      chk($sformatf("%s cyc T+%0d", tag, n), {26'd0, busy, evt_valid, evt_addr, step_done}, {26'd0, want});
      if (n <= done_at) begin
        step_start = (n == p1) || (n == p2);
        tick();
        step_start = 1'b0;
      end
    end
    chk($sformatf("%s neuron spikes", tag), nspk - c0, ref_spikes(m0, vec));
  endtask

  typedef struct {
    string      tag;
    logic [7:0] vec;
    int         done_at;
  } step_vec_t;

  step_vec_t tbl[6];

  initial begin
    int drops_want, ovr_want, sat_want, sat_ovr_want;
    logic idle_seen;

    tbl[0] = '{"a4", 8'b1010_0100, 6};
    tbl[1] = '{"zero", 8'h00, 3};
    tbl[2] = '{"ff", 8'hFF, 11};
    tbl[3] = '{"bit0", 8'h01, 4};
    tbl[4] = '{"bit7", 8'h80, 4};
    tbl[5] = '{"alt55", 8'h55, 7};

`ifdef SPIKE_SCHED_OVERRUN_EN
    drops_want = 2; ovr_want = 1; sat_want = 255; sat_ovr_want = 1;
`else
    drops_want = 0; ovr_want = 0; sat_want = 0; sat_ovr_want = 0;
`endif

    resetn = 1'b1;
    repeat (3) tick();
    chk("reset outputs", {busy, evt_valid, evt_addr, step_done, overrun, drop_cnt}, '0);
    resetn = 1'b0;
    tick();

    // Each step starts in the idle cycle right after the previous DONE.
    for (int t = 0; t < 6; t++) run_step(tbl[t].tag, tbl[t].vec, tbl[t].done_at, -1, -1);

    // step_start at T+2 and in the DONE cycle must both be ignored.
    run_step("ignored", 8'b1010_0100, 6, 2, 6);
    chk("overrun after 2 drops", overrun, ovr_want);
    chk("drop_cnt after 2 drops", drop_cnt, drops_want);

    // Reset asserted on T+2 aborts the step.
    tick();
    spike_vec  = 8'b0000_1111;
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    chk("abort T+1", {busy, evt_valid, evt_addr, step_done}, 6'b1_1_000_0);
    tick();
    chk("abort T+2", {busy, evt_valid, evt_addr, step_done}, 6'b1_1_001_0);
    resetn = 1'b1;
    tick();
    chk("abort T+3", {busy, evt_valid, evt_addr, step_done}, 6'b0);
    chk("abort clears overrun", {overrun, drop_cnt}, '0);
    resetn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("abort quiet %0d", i), {busy, evt_valid, step_done}, 3'b000);
    end
    run_step("post-reset", 8'b0000_1111, 7, -1, -1);

    // Hold step_start high through many long steps to force well over 255 drops.
    spike_vec  = 8'hFF;
    step_start = 1'b1;
    repeat (300) tick();
    step_start = 1'b0;
    idle_seen  = 1'b0;
    for (int i = 0; i < 20 && !idle_seen; i++) begin
      tick();
      idle_seen = !busy;
    end
    chk("drain to idle", idle_seen, 1'b1);
    chk("drop_cnt saturated", drop_cnt, sat_want);
    chk("overrun sticky", overrun, sat_ovr_want);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
